// File: rtl/intel_vvp_remosaic_mode_sched.sv
// Purpose : frame-boundary scheduler that commits a shadowed conv-mode to the remosaic datapath.
// Latency : accept at T with a gap present -> new mode and mode_update at T+3+C_DRAIN_CYCLES.
// Backpr. : req_ready low while draining/applying; vid_hold stalls upstream frame starts.
// Ports   : main_clock/main_reset_n (async active-low); req_conv_mode/req_valid/req_ready request
//           handshake; vid_sof/vid_eof frame markers in, vid_hold out; active_conv_mode/mode_update
//           to the datapath; pending plus saturating applied/overwrite/abort status counters.
module intel_vvp_remosaic_mode_sched #(
  parameter logic [7:0] C_CONV_MODE    = 8'b00010110,
  parameter int         C_DRAIN_CYCLES = 16,
  parameter int         C_CNT_WIDTH    = 16
) (
  input  logic                   main_clock,
  input  logic                   main_reset_n,
  input  logic [7:0]             req_conv_mode,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   vid_sof,
  input  logic                   vid_eof,
  output logic                   vid_hold,
  output logic [7:0]             active_conv_mode,
  output logic                   mode_update,
  output logic                   pending,
  output logic [C_CNT_WIDTH-1:0] applied_count,
  output logic [C_CNT_WIDTH-1:0] overwrite_count,
  output logic [C_CNT_WIDTH-1:0] abort_count
);

  typedef enum logic [1:0] {IDLE, PENDING, DRAIN, APPLY} state_t;

  // With no drain interval the gap goes straight to the one-cycle commit.
  localparam logic [7:0] DRAIN_LOAD = (C_DRAIN_CYCLES == 0) ? 8'd0 : 8'(C_DRAIN_CYCLES - 1);
  localparam state_t     GAP_STATE  = (C_DRAIN_CYCLES == 0) ? APPLY : DRAIN;
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = {C_CNT_WIDTH{1'b1}};

  state_t     state, state_nxt;
  logic       in_frame;
  logic [7:0] shadow, shadow_nxt;
  logic [7:0] drain_cnt, drain_cnt_nxt;
  logic       accept, same_mode, gap;
  logic       commit, inc_overwrite, inc_abort;

  assign req_ready = (state == IDLE) || (state == PENDING);
  assign pending   = (state != IDLE);
  assign vid_hold  = (state == DRAIN) || (state == APPLY);

  assign accept    = req_valid && req_ready;
  assign same_mode = (req_conv_mode == active_conv_mode);
  // An SOF in the current cycle means a frame is starting, so it is not a gap.
  assign gap       = !in_frame && !vid_sof;

  always_comb begin
    state_nxt     = state;
    shadow_nxt    = shadow;
    drain_cnt_nxt = drain_cnt;
    commit        = 1'b0;
    inc_overwrite = 1'b0;
    inc_abort     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !same_mode) begin
          shadow_nxt = req_conv_mode;
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        if (accept && same_mode) begin
          // Cancel wins over a simultaneous gap.
          shadow_nxt    = req_conv_mode;
          inc_overwrite = 1'b1;
          state_nxt     = IDLE;
        end else begin
          if (accept) begin
            shadow_nxt    = req_conv_mode;
            inc_overwrite = 1'b1;
          end
          if (gap) begin
            state_nxt     = GAP_STATE;
            drain_cnt_nxt = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (vid_sof) begin
          // Upstream ignored vid_hold; keep the shadow and retry at the next gap.
          inc_abort = 1'b1;
          state_nxt = PENDING;
        end else if (drain_cnt == 8'd0) begin
          state_nxt = APPLY;
        end else begin
          drain_cnt_nxt = drain_cnt - 8'd1;
        end
      end
      APPLY: begin
        commit    = 1'b1;
        inc_abort = vid_sof;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge main_clock or negedge main_reset_n) begin
    if (!main_reset_n) begin
      state            <= IDLE;
      in_frame         <= 1'b0;
      shadow           <= C_CONV_MODE;
      drain_cnt        <= 8'd0;
      active_conv_mode <= C_CONV_MODE;
      mode_update      <= 1'b0;
      applied_count    <= '0;
      overwrite_count  <= '0;
      abort_count      <= '0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      drain_cnt <= drain_cnt_nxt;
      // EOF wins so a same-cycle SOF+EOF leaves the stream out of frame.
      if (vid_eof)      in_frame <= 1'b0;
      else if (vid_sof) in_frame <= 1'b1;
      mode_update <= commit && (shadow != active_conv_mode);
      if (commit) active_conv_mode <= shadow;
      if (commit && applied_count != CNT_MAX)
        applied_count <= applied_count + 1'b1;
      if (inc_overwrite && overwrite_count != CNT_MAX)
        overwrite_count <= overwrite_count + 1'b1;
      if (inc_abort && abort_count != CNT_MAX)
        abort_count <= abort_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_intel_vvp_remosaic_mode_sched.sv
module tb_intel_vvp_remosaic_mode_sched;

  logic        main_clock   = 1'b0;
  logic        main_reset_n = 1'b0;
  logic [7:0]  req_conv_mode = 8'h16;
  logic        req_valid = 1'b0;
  logic        vid_sof = 1'b0;
  logic        vid_eof = 1'b0;

  logic        req_ready, vid_hold, mode_update, pending;
  logic [7:0]  active_conv_mode;
  logic [15:0] applied_count, overwrite_count, abort_count;

  logic        req_ready_2, vid_hold_2, mode_update_2, pending_2;
  logic [7:0]  active_conv_mode_2;
  logic [1:0]  applied_count_2, overwrite_count_2, abort_count_2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  always #5 main_clock = ~main_clock;

  intel_vvp_remosaic_mode_sched #(.C_DRAIN_CYCLES(4)) dut (
    .main_clock(main_clock), .main_reset_n(main_reset_n),
    .req_conv_mode(req_conv_mode), .req_valid(req_valid), .req_ready(req_ready),
    .vid_sof(vid_sof), .vid_eof(vid_eof), .vid_hold(vid_hold),
    .active_conv_mode(active_conv_mode), .mode_update(mode_update), .pending(pending),
    .applied_count(applied_count), .overwrite_count(overwrite_count), .abort_count(abort_count)
  );

  // Narrow-counter copy fed the same stimulus, used for saturation.
  intel_vvp_remosaic_mode_sched #(.C_DRAIN_CYCLES(4), .C_CNT_WIDTH(2)) dut2 (
    .main_clock(main_clock), .main_reset_n(main_reset_n),
    .req_conv_mode(req_conv_mode), .req_valid(req_valid), .req_ready(req_ready_2),
    .vid_sof(vid_sof), .vid_eof(vid_eof), .vid_hold(vid_hold_2),
    .active_conv_mode(active_conv_mode_2), .mode_update(mode_update_2), .pending(pending_2),
    .applied_count(applied_count_2), .overwrite_count(overwrite_count_2),
    .abort_count(abort_count_2)
  );

  // Scoreboard consumer: every mode_update must match the oldest expected commit.
  always @(negedge main_clock) begin
    if (main_reset_n && mode_update) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_update: got mode %0h, required no update", active_conv_mode);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (active_conv_mode !== e)
          $display("FAIL sb_mode: got %0h required %0h", active_conv_mode, e);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge main_clock);
    #1;
  endtask

  task automatic do_reset;
    main_reset_n  = 1'b0;
    req_valid     = 1'b0;
    vid_sof       = 1'b0;
    vid_eof       = 1'b0;
    req_conv_mode = 8'h16;
    exp_q.delete();
    repeat (2) @(posedge main_clock);
    #1 main_reset_n = 1'b1;
    tick();
  endtask

  // Drives one request for one cycle; caller guarantees req_ready is high.
  task automatic send_req(input logic [7:0] m);
    req_conv_mode = m;
    req_valid     = 1'b1;
    tick();
    req_valid     = 1'b0;
  endtask

  task automatic wait_update(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (mode_update) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit seen;
    do_reset();
    exp_q.push_back(8'h21);
    send_req(8'h21);
    wait_update(30, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL rst_pre_commit: got %0b required 1", seen); else n_pass++;
    send_req(8'h16);
    tick(); tick();
    n_checks++; if (vid_hold !== 1'b1) $display("FAIL rst_pre_hold: got %0b required 1", vid_hold); else n_pass++;
    #2 main_reset_n = 1'b0;
    #1;
    n_checks++; if (active_conv_mode !== 8'h16) $display("FAIL rst_active: got %0h required 16", active_conv_mode); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %0b required 1", req_ready); else n_pass++;
    n_checks++; if (vid_hold !== 1'b0) $display("FAIL rst_hold: got %0b required 0", vid_hold); else n_pass++;
    n_checks++; if (pending !== 1'b0) $display("FAIL rst_pending: got %0b required 0", pending); else n_pass++;
    n_checks++; if (mode_update !== 1'b0) $display("FAIL rst_update: got %0b required 0", mode_update); else n_pass++;
    n_checks++; if (applied_count !== 16'd0) $display("FAIL rst_applied: got %0d required 0", applied_count); else n_pass++;
    n_checks++; if (overwrite_count !== 16'd0) $display("FAIL rst_overwrite: got %0d required 0", overwrite_count); else n_pass++;
    n_checks++; if (abort_count !== 16'd0) $display("FAIL rst_abort: got %0d required 0", abort_count); else n_pass++;
  endtask

  task automatic test_commit_latency;
    do_reset();
    exp_q.push_back(8'h21);
    req_conv_mode = 8'h21;
    req_valid     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        req_valid = 1'b0;
        n_checks++; if (pending !== 1'b1) $display("FAIL lat_pending: got %0b required 1", pending); else n_pass++;
      end
      n_checks++;
      if (vid_hold !== (k >= 2 && k <= 6))
        $display("FAIL lat_hold T+%0d: got %0b required %0b", k, vid_hold, (k >= 2 && k <= 6));
      else n_pass++;
      n_checks++;
      if (mode_update !== (k == 7))
        $display("FAIL lat_update T+%0d: got %0b required %0b", k, mode_update, (k == 7));
      else n_pass++;
    end
    n_checks++; if (active_conv_mode !== 8'h21) $display("FAIL lat_active: got %0h required 21", active_conv_mode); else n_pass++;
    n_checks++; if (applied_count !== 16'd1) $display("FAIL lat_applied: got %0d required 1", applied_count); else n_pass++;
  endtask

  task automatic test_mid_frame;
    do_reset();
    vid_sof = 1'b1;           // cycle T
    tick(); vid_sof = 1'b0;   // T+1
    tick(); tick();           // T+3
    exp_q.push_back(8'h21);
    send_req(8'h21);          // T+4
    n_checks++; if (pending !== 1'b1) $display("FAIL mf_pending: got %0b required 1", pending); else n_pass++;
    repeat (46) tick();       // T+50
    n_checks++; if (vid_hold !== 1'b0) $display("FAIL mf_hold_inframe: got %0b required 0", vid_hold); else n_pass++;
    vid_eof = 1'b1;
    tick(); vid_eof = 1'b0;   // T+51: gap seen this cycle
    n_checks++; if (vid_hold !== 1'b0) $display("FAIL mf_hold_t51: got %0b required 0", vid_hold); else n_pass++;
    tick();                   // T+52: draining
    n_checks++; if (vid_hold !== 1'b1) $display("FAIL mf_hold_t52: got %0b required 1", vid_hold); else n_pass++;
    for (int c = 53; c <= 56; c++) begin
      tick();
      n_checks++;
      if (active_conv_mode !== 8'h16 || mode_update !== 1'b0)
        $display("FAIL mf_early_change T+%0d: got mode %0h upd %0b required 16/0", c, active_conv_mode, mode_update);
      else n_pass++;
    end
    tick();                   // T+57
    n_checks++;
    if (active_conv_mode !== 8'h21 || mode_update !== 1'b1)
      $display("FAIL mf_commit: got mode %0h upd %0b required 21/1", active_conv_mode, mode_update);
    else n_pass++;
  endtask

  task automatic test_overwrite_cancel;
    bit saw_upd;
    do_reset();
    vid_sof = 1'b1;
    tick(); vid_sof = 1'b0;
    send_req(8'h21);
    n_checks++; if (pending !== 1'b1) $display("FAIL oc_pending: got %0b required 1", pending); else n_pass++;
    send_req(8'h33);
    send_req(8'h16);
    n_checks++; if (pending !== 1'b0) $display("FAIL oc_idle: got %0b required 0", pending); else n_pass++;
    n_checks++; if (overwrite_count !== 16'd2) $display("FAIL oc_overwrite: got %0d required 2", overwrite_count); else n_pass++;
    saw_upd = 1'b0;
    repeat (3) begin tick(); saw_upd |= mode_update; end
    vid_eof = 1'b1;
    tick(); vid_eof = 1'b0;
    repeat (10) begin tick(); saw_upd |= mode_update; end
    n_checks++; if (saw_upd !== 1'b0) $display("FAIL oc_no_update: got %0b required 0", saw_upd); else n_pass++;
    n_checks++; if (active_conv_mode !== 8'h16) $display("FAIL oc_active: got %0h required 16", active_conv_mode); else n_pass++;
    n_checks++; if (applied_count !== 16'd0) $display("FAIL oc_applied: got %0d required 0", applied_count); else n_pass++;
  endtask

  task automatic test_abort;
    bit seen;
    do_reset();
    exp_q.push_back(8'h21);
    send_req(8'h21);          // T+1 pending
    tick();                   // T+2 drain cycle 1
    n_checks++; if (vid_hold !== 1'b1) $display("FAIL ab_hold_pre: got %0b required 1", vid_hold); else n_pass++;
    tick();                   // T+3 drain cycle 2
    vid_sof = 1'b1;
    tick(); vid_sof = 1'b0;
    n_checks++; if (abort_count !== 16'd1) $display("FAIL ab_count: got %0d required 1", abort_count); else n_pass++;
    n_checks++; if (vid_hold !== 1'b0) $display("FAIL ab_hold: got %0b required 0", vid_hold); else n_pass++;
    n_checks++;
    if (pending !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL ab_state: got pending %0b ready %0b required 1/1", pending, req_ready);
    else n_pass++;
    repeat (5) tick();
    n_checks++; if (active_conv_mode !== 8'h16) $display("FAIL ab_no_commit: got %0h required 16", active_conv_mode); else n_pass++;
    vid_eof = 1'b1;
    tick(); vid_eof = 1'b0;
    wait_update(20, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL ab_retry_timeout: got %0b required 1", seen); else n_pass++;
    n_checks++; if (applied_count !== 16'd1) $display("FAIL ab_applied: got %0d required 1", applied_count); else n_pass++;
    n_checks++; if (active_conv_mode !== 8'h21) $display("FAIL ab_active: got %0h required 21", active_conv_mode); else n_pass++;
  endtask

  task automatic test_same_mode_saturation;
    bit seen;
    logic [7:0] m;
    logic [1:0] exp_sat;
    do_reset();
    send_req(8'h16);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (pending !== 1'b0 || vid_hold !== 1'b0)
        $display("FAIL sm_state: got pending %0b hold %0b required 0/0", pending, vid_hold);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (overwrite_count !== 16'd0 || applied_count !== 16'd0 || abort_count !== 16'd0)
      $display("FAIL sm_counts: got %0d/%0d/%0d required 0/0/0", overwrite_count, applied_count, abort_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      m = (i % 2 == 0) ? 8'h21 : 8'h16;
      exp_q.push_back(m);
      send_req(m);
      wait_update(30, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL sat_commit%0d_timeout: got %0b required 1", i, seen); else n_pass++;
      exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_checks++;
      if (applied_count_2 !== exp_sat)
        $display("FAIL sat_applied2_%0d: got %0d required %0d", i, applied_count_2, exp_sat);
      else n_pass++;
    end
    n_checks++; if (applied_count !== 16'd5) $display("FAIL sat_applied16: got %0d required 5", applied_count); else n_pass++;
    n_checks++; if (active_conv_mode_2 !== 8'h21) $display("FAIL sat_active2: got %0h required 21", active_conv_mode_2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_commit_latency();
    test_mid_frame();
    test_overwrite_cancel();
    test_abort();
    test_same_mode_saturation();
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d queued commits required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
